// File: rtl/pc_seq_pkg.sv
// Shared defaults and the next-PC source encoding for the fetch PC sequencer.
// Included by pc_ras and pc_sequencer.
package pc_seq_pkg;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0040_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int unsigned DEF_PC_INC       = 4;
    localparam int unsigned DEF_RAS_DEPTH    = 4;

    typedef enum logic [2:0] {
        SRC_RESET = 3'd0,
        SRC_EXC   = 3'd1,
        SRC_REDIR = 3'd2,
        SRC_HOLD  = 3'd3,
        SRC_CALL  = 3'd4,
        SRC_RET   = 3'd5,
        SRC_SEQ   = 3'd6
    } src_e;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack: push/pop/replace, full-push overwrites the oldest entry.
// Updates on the falling clk edge; top/empty/full are read combinationally from state.
module pc_ras
    import pc_seq_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = DEF_RAS_DEPTH
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         empty,
    output logic         full,
    output logic         overflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] top_ptr;
    logic [PW-1:0] nxt_ptr;
    logic [CW-1:0] count;
    logic          replace;

    assign nxt_ptr = top_ptr + 1'b1;
    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign top     = mem[top_ptr];
    // Pop+push on a non-empty stack rewrites the top in place; on an empty stack it is a plain push.
    assign replace = push && pop && !empty;

    always_ff @(negedge clk) begin
        if (!reset) begin
            top_ptr  <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (push && !replace) begin
            top_ptr <= nxt_ptr;
            if (full) begin
                overflow <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end else if (pop && !push) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
        end
    end

    always_ff @(negedge clk) begin
        if (reset && !clear && push) begin
            if (replace) begin
                mem[top_ptr] <= push_data;
            end else begin
                mem[nxt_ptr] <= push_data;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with prioritised next-PC select (exc > redirect > stall > call > ret > seq) and RAS.
// New PC visible one falling edge after sampling; optional PC_ALIGN_CHECK_EN turns misaligned redirects into exceptions.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int unsigned       N_BITS       = 32,
    parameter logic [N_BITS-1:0] RESET_VECTOR = N_BITS'(DEF_RESET_VECTOR),
    parameter logic [N_BITS-1:0] EXC_VECTOR   = N_BITS'(DEF_EXC_VECTOR),
    parameter int unsigned       PC_INC       = DEF_PC_INC,
    parameter int unsigned       RAS_DEPTH    = DEF_RAS_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              exc_i,
    input  logic              redirect_valid_i,
    input  logic [N_BITS-1:0] redirect_pc_i,
    input  logic              call_i,
    input  logic [N_BITS-1:0] call_target_i,
    input  logic              ret_i,
    output logic [N_BITS-1:0] pc_value_o,
    output logic [N_BITS-1:0] pc_plus_o,
    output logic              ras_empty_o,
    output logic              ras_full_o,
    output logic              ras_overflow_o,
`ifdef PC_ALIGN_CHECK_EN
    output logic              misalign_o,
`endif
    output logic              ret_miss_o
);

    src_e              src;
    logic              ras_push;
    logic              ras_pop;
    logic              ras_clear;
    logic [N_BITS-1:0] ras_top;
    logic              ret_miss_d;
    logic              redir_bad;

`ifdef PC_ALIGN_CHECK_EN
    assign redir_bad = redirect_valid_i && (redirect_pc_i[1:0] != 2'b00);
`else
    assign redir_bad = 1'b0;
`endif

    assign pc_plus_o = pc_value_o + N_BITS'(PC_INC);

    always_comb begin
        src        = SRC_SEQ;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        ret_miss_d = 1'b0;
        if (!reset) begin
            src = SRC_RESET;
        end else if (exc_i || redir_bad) begin
            src = SRC_EXC;
        end else if (redirect_valid_i) begin
            src = SRC_REDIR;
        end else if (!enable) begin
            src = SRC_HOLD;
        end else if (call_i) begin
            src      = SRC_CALL;
            ras_push = 1'b1;
            ras_pop  = ret_i;
        end else if (ret_i && !ras_empty_o) begin
            src     = SRC_RET;
            ras_pop = 1'b1;
        end else begin
            ret_miss_d = ret_i;
        end
    end

    assign ras_clear = (src == SRC_EXC);

    always_ff @(negedge clk) begin
        case (src)
            SRC_RESET: pc_value_o <= RESET_VECTOR;
            SRC_EXC:   pc_value_o <= EXC_VECTOR;
            SRC_REDIR: pc_value_o <= redirect_pc_i;
            SRC_HOLD:  pc_value_o <= pc_value_o;
            SRC_CALL:  pc_value_o <= call_target_i;
            SRC_RET:   pc_value_o <= ras_top;
            default:   pc_value_o <= pc_plus_o;
        endcase
        ret_miss_o <= ret_miss_d;
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(negedge clk) begin
        if (!reset) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= redir_bad && !exc_i;
        end
    end
`endif

    pc_ras #(
        .W     (N_BITS),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset     (reset),
        .clear     (ras_clear),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus_o),
        .top       (ras_top),
        .empty     (ras_empty_o),
        .full      (ras_full_o),
        .overflow  (ras_overflow_o)
    );

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Next-generation program counter for the MIPS pipeline fetch stage.
- Holds the fetch PC and selects the next PC from these sources:
  - sequential increment,
  - exception vector,
  - resolved redirect from a later stage,
  - call target,
  - return-address-stack (RAS) prediction.
- Parametrised in width, reset/exception vectors, increment and RAS depth.
- Drives the instruction memory address and the IF/ID pc+4 field.

Parameters:
- N_BITS, 32, PC and address width.
- RESET_VECTOR, 32'h0040_0000, PC value loaded on reset.
- EXC_VECTOR, 32'h8000_0180, PC value loaded on exception.
- PC_INC, 4, sequential increment.
- RAS_DEPTH, 4, return-address-stack entries (power of 2, >=2).

Ports:
- clk  in  1  clock; all state updates on the falling edge.
- reset  in  1  synchronous, active-low reset, sampled on the active clk edge.
- enable  in  1  1 = advance, 0 = stall (hazard unit).
- exc_i  in  1  exception request.
- redirect_valid_i  in  1  resolved branch/jump redirect.
- redirect_pc_i  in  N_BITS  redirect target.
- call_i  in  1  fetch-decoded jal.
- call_target_i  in  N_BITS  jal target.
- ret_i  in  1  fetch-decoded jr $ra.
- pc_value_o  out  N_BITS  current fetch PC.
- pc_plus_o  out  N_BITS  pc_value_o + PC_INC (combinational).
- ras_empty_o  out  1  RAS holds 0 entries.
- ras_full_o  out  1  RAS holds RAS_DEPTH entries.
- ras_overflow_o  out  1  sticky: a push occurred while the RAS was full.
- ret_miss_o  out  1  registered one-cycle pulse: ret_i seen with the RAS empty.

Behaviour:
- Reset (reset==0 at the clk edge):
  - pc_value_o = RESET_VECTOR.
  - RAS count = 0; ras_empty_o = 1, ras_full_o = 0.
  - ras_overflow_o = 0, ret_miss_o = 0.
  - Reset applied mid-operation overrides every other input in that cycle.
- Next-PC priority, evaluated each edge:
  1. exc_i: pc <= EXC_VECTOR; RAS count cleared; ras_overflow_o kept. Acts regardless of enable.
  2. redirect_valid_i: pc <= redirect_pc_i; RAS unchanged. Acts regardless of enable (flush overrides stall).
  3. enable==0: pc and RAS hold; ret_miss_o <= 0.
  4. call_i && ret_i: pop then push the new return address, so the top is replaced and the count is unchanged (count 0 becomes 1); pc <= call_target_i.
  5. call_i: push pc_value_o+PC_INC; pc <= call_target_i.
  6. ret_i with RAS non-empty: pc <= top entry; pop.
  7. ret_i with RAS empty: pc <= pc_value_o+PC_INC; ret_miss_o <= 1 for one cycle.
  8. Otherwise: pc <= pc_value_o+PC_INC.
- Lower-priority sources are ignored in the same cycle. call_i/ret_i are ignored whenever exc_i or redirect_valid_i is high.
- Arithmetic: addition is modulo 2^N_BITS; pc 32'hFFFF_FFFC + 4 wraps to 0.
- RAS structure: circular buffer with a top pointer and count (0..RAS_DEPTH).
- Push while full: overwrites the oldest entry (wraps), count stays RAS_DEPTH, ras_overflow_o <= 1 (sticky until reset).
- Pop when empty never occurs; case 7 handles it.
- Latency:
  - A new PC is visible one clk edge after the selecting inputs are sampled.
  - pc_plus_o follows pc_value_o combinationally.

Optional Feature:
- Macro: PC_ALIGN_CHECK_EN.
- Defined:
  - Redirect with redirect_pc_i[1:0] != 0 is treated as an exception: pc <= EXC_VECTOR, RAS cleared.
  - Extra output port misalign_o (1 bit) pulses for one cycle.
- Undefined:
  - No misalign_o port.
  - Redirect targets are taken unmodified.

Decomposition:
- Package pc_seq_pkg:
  - default RESET_VECTOR, EXC_VECTOR and PC_INC localparams;
  - next-PC source enum (SRC_RESET, SRC_EXC, SRC_REDIR, SRC_HOLD, SRC_CALL, SRC_RET, SRC_SEQ).
- Sub-module pc_ras holds the circular return-address stack.
  - Ports: clk, reset, clear, push, pop, push_data, top, empty, full, overflow.
- pc_sequencer keeps the PC register, the priority mux and ret_miss_o.

Test Plan:
- Reset low for 2 edges, then release -> pc_value_o=32'h0040_0000, then 32'h0040_0004 and 32'h0040_0008 on the next edges; ras_empty_o=1.
- enable=0 for 3 cycles at pc 32'h0040_0008 -> pc held; then redirect_valid_i=1 with redirect_pc_i=32'h0040_0100 while enable=0 -> pc=32'h0040_0100 next edge.
- Three calls and three returns:
  - call_i at pc 32'h0040_0010 (target 32'h0040_0200), then at 32'h0040_0200 (target 32'h0040_0300), then at 32'h0040_0300 (target 32'h0040_0400).
  - Then three ret_i in a row -> pc sequence 32'h0040_0304, 32'h0040_0204, 32'h0040_0014; ras_empty_o=1.
- Five calls with RAS_DEPTH=4 -> ras_full_o=1 and ras_overflow_o=1; four rets return the newest four addresses in LIFO order; a fifth ret -> ret_miss_o pulses and pc advances by 4.
- Simultaneous exc_i, redirect_valid_i and call_i -> pc=32'h8000_0180, RAS count 0; a separate cycle with pc=32'hFFFF_FFFC and no requests -> pc=0.
- PC_ALIGN_CHECK_EN defined, redirect_pc_i=32'h0040_0102 -> pc=32'h8000_0180 and misalign_o=1 for one cycle; with the macro undefined -> pc=32'h0040_0102.
